onchip_ring_master: RTL and testbench

Avalon-MM master that drives one 16-bit port of the on-chip dual-port RAM as a ring-buffer FIFO. Accepts a valid/ready sample stream, writes it into a configurable window of the RAM, reads it back in order and presents it as a valid/ready output stream. It sits between the sensor/audio sample pipeline and its consumer, and uses the RAM as deep storage through a port with no waitrequest and a fixed read latency of 1.

---
 rtl/onchip_ring_master_pkg.sv | 29 ++
 rtl/onchip_ring_master_out_buf.sv | 40 ++++
 rtl/onchip_ring_master.sv | 127 ++++++++++++
 tb/tb_onchip_ring_master.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_ring_master_pkg.sv
// Shared types and helpers for the on-chip RAM ring-buffer master.
package onchip_ring_master_pkg;

    localparam int unsigned AVM_ADDR_W = 16;
    localparam int unsigned AVM_DATA_W = 16;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } grant_e;

    typedef struct packed {
        logic [AVM_ADDR_W-1:0]   address;
        logic [AVM_DATA_W/8-1:0] byteenable;
        logic                    chipselect;
        logic                    write;
        logic [AVM_DATA_W-1:0]   writedata;
        logic                    clken;
    } avm_master_t;

    // Advance a ring pointer, wrapping from the last window word back to base.
    function automatic int unsigned ring_next(input int unsigned ptr,
                                              input int unsigned base,
                                              input int unsigned depth);
        return (ptr == base + depth - 1) ? base : ptr + 1;
    endfunction

endpackage

// File: rtl/onchip_ring_master_out_buf.sv
// Two-entry output FIFO holding RAM read returns until the consumer takes them.
module ring_out_buf #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        entries_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_idx_q;
    logic              rd_idx_q;
    logic [1:0]        cnt_q;

    // Pointer and occupancy bookkeeping; clear has priority over any push/pop.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_idx_q <= ~wr_idx_q;
            if (pop_i)  rd_idx_q <= ~rd_idx_q;
            cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wr_idx_q] <= push_data_i;
    end

    assign head_o    = mem_q[rd_idx_q];
    assign entries_o = cnt_q;

endmodule

// File: rtl/onchip_ring_master.sv
// Avalon-MM master using one RAM port as a ring-buffer FIFO between two streams.
module onchip_ring_master
    import onchip_ring_master_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 65536
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                snk_valid,
    output logic                snk_ready,
    input  logic [DATA_W-1:0]   snk_data,
    output logic                src_valid,
    input  logic                src_ready,
    output logic [DATA_W-1:0]   src_data,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_chipselect,
    output logic                m_write,
    output logic                m_clken,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic [DATA_W-1:0]   m_readdata,
    output logic [ADDR_W:0]     level
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_L  = ADDR_W'(BASE_ADDR);

    grant_e            last_q, last_d, gnt;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              inflight_q, inflight_d;
    logic              wr_cand, rd_cand, pop, clear;
    logic [1:0]        entries;
    logic [DATA_W-1:0] head;
    avm_master_t       avm;

    assign clear = !reset_n || flush;

    // Arbiter: one access per cycle, alternating when both sides want the port.
    always_comb begin
        gnt     = GNT_NONE;
        wr_cand = snk_valid && (level_q != DEPTH_L);
        rd_cand = (level_q != '0) && ((entries + {1'b0, inflight_q}) < 2'd2);
        if (!clear) begin
            if (wr_cand && rd_cand) gnt = (last_q == GNT_WR) ? GNT_RD : GNT_WR;
            else if (wr_cand)       gnt = GNT_WR;
            else if (rd_cand)       gnt = GNT_RD;
        end
    end

    // Next-state for pointers, level, in-flight flag and arbitration history.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        last_d     = (gnt != GNT_NONE) ? gnt : last_q;
        inflight_d = (gnt == GNT_RD);
        case (gnt)
            GNT_WR: begin
                wr_ptr_d = ADDR_W'(ring_next(32'(wr_ptr_q), BASE_ADDR, DEPTH));
                level_d  = level_q + (ADDR_W+1)'(1);
            end
            GNT_RD: begin
                rd_ptr_d = ADDR_W'(ring_next(32'(rd_ptr_q), BASE_ADDR, DEPTH));
                level_d  = level_q - (ADDR_W+1)'(1);
            end
            default: ;
        endcase
    end

    // State register; flush clears exactly like reset.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr_q   <= BASE_L;
            rd_ptr_q   <= BASE_L;
            level_q    <= '0;
            inflight_q <= 1'b0;
            last_q     <= GNT_NONE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            inflight_q <= inflight_d;
            last_q     <= last_d;
        end
    end

    // Return data lands one cycle after the read grant; a clear drops it.
    ring_out_buf #(.DATA_W(DATA_W)) u_out_buf (
        .clk         (clk),
        .clr_i       (clear),
        .push_i      (inflight_q),
        .push_data_i (m_readdata),
        .pop_i       (pop),
        .head_o      (head),
        .entries_o   (entries)
    );

    // Assemble the Avalon master request for this cycle.
    always_comb begin
        avm            = '0;
        avm.address    = AVM_ADDR_W'((gnt == GNT_RD) ? rd_ptr_q : wr_ptr_q);
        avm.byteenable = '1;
        avm.chipselect = (gnt != GNT_NONE);
        avm.write      = (gnt == GNT_WR);
        avm.writedata  = AVM_DATA_W'(snk_data);
        avm.clken      = 1'b1;
    end

    assign m_address    = ADDR_W'(avm.address);
    assign m_byteenable = (DATA_W/8)'(avm.byteenable);
    assign m_chipselect = avm.chipselect;
    assign m_write      = avm.write;
    assign m_writedata  = DATA_W'(avm.writedata);
    assign m_clken      = avm.clken;

    assign snk_ready = (gnt == GNT_WR);
    assign src_valid = reset_n && (entries != 2'd0);
    assign src_data  = head;
    assign pop       = src_valid && src_ready;
    assign level     = reset_n ? level_q : '0;

endmodule

// File: tb/tb_onchip_ring_master.sv
// Directed bench for onchip_ring_master with a 1-cycle-latency RAM model.
module tb_onchip_ring_master;

    logic        clk = 1'b0;
    logic        reset_n, flush;
    logic        snk_valid, snk_ready, src_valid, src_ready;
    logic [15:0] snk_data, src_data, m_writedata;
    logic [15:0] m_readdata = '0;
    logic [15:0] m_address;
    logic        m_chipselect, m_write, m_clken;
    logic [1:0]  m_byteenable;
    logic [16:0] level;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rd_iss = 0;
    int pops   = 0;
    bit rand_rdy = 1'b0;

    logic [15:0] ram [0:65535];
    logic [15:0] out_q[$], sent_q[$], wr_addr_q[$], rd_addr_q[$];
    bit          gnt_w_q[$];
    int          gnt_c_q[$];

    always #5 clk = ~clk;

    onchip_ring_master #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .BASE_ADDR ('h0100),
        .DEPTH     (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .snk_valid    (snk_valid),
        .snk_ready    (snk_ready),
        .snk_data     (snk_data),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_data     (src_data),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_clken      (m_clken),
        .m_byteenable (m_byteenable),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .level        (level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RAM: write on the grant edge, read data valid the following cycle.
    always @(posedge clk) begin
        if (m_chipselect && m_write)  ram[m_address] <= m_writedata;
        if (m_chipselect && !m_write) m_readdata <= ram[m_address];
    end

    // Random consumer backpressure when enabled.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 src_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // Bus/stream monitor with per-cycle invariants.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n || flush) begin
            rd_iss = 0;
            pops   = 0;
        end else begin
            if (m_chipselect) begin
                gnt_w_q.push_back(m_write);
                gnt_c_q.push_back(cyc);
                if (m_write) wr_addr_q.push_back(m_address);
                else begin
                    rd_addr_q.push_back(m_address);
                    rd_iss++;
                end
            end
            if (src_valid && src_ready) begin
                out_q.push_back(src_data);
                pops++;
            end
            chk("credit_bound", 32'((rd_iss - pops) <= 2), 1);
            chk("level_max", 32'(level <= 17'd8), 1);
            if (level == 17'd8) chk("no_wr_full", 32'(m_write), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        flush     = 1'b0;
        snk_valid = 1'b1;
        snk_data  = 16'hDEAD;
        src_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_snk_ready", 32'(snk_ready), 0);
            chk("rst_src_valid", 32'(src_valid), 0);
            chk("rst_cs", 32'(m_chipselect), 0);
            chk("rst_write", 32'(m_write), 0);
            chk("rst_level", 32'(level), 0);
            chk("rst_clken", 32'(m_clken), 1);
            chk("rst_be", 32'(m_byteenable), 3);
            tick();
        end
        reset_n   = 1'b1;
        snk_valid = 1'b0;
        src_ready = 1'b0;
        out_q.delete();
        sent_q.delete();
        wr_addr_q.delete();
        rd_addr_q.delete();
        gnt_w_q.delete();
        gnt_c_q.delete();
    endtask

    task automatic push(input logic [15:0] d);
        bit acc = 1'b0;
        snk_valid = 1'b1;
        snk_data  = d;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            if (snk_ready) acc = 1'b1;
            tick();
        end
        snk_valid = 1'b0;
        if (acc) sent_q.push_back(d);
        else chk("push_timeout", 0, 1);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, 32'(out_q.size()), 32'(sent_q.size()));
        foreach (sent_q[k])
            if (k < out_q.size()) chk(tag, 32'(out_q[k]), 32'(sent_q[k]));
    endtask

    initial begin
        // Scenario 1: three samples, consumer stalled, then released
        do_reset();
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        idle(3);
        @(negedge clk);
        chk("s1_nwr", 32'(wr_addr_q.size()), 3);
        for (int k = 0; k < 3; k++)
            if (k < wr_addr_q.size()) chk("s1_waddr", 32'(wr_addr_q[k]), 32'h100 + 32'(k));
        chk("s1_nrd", 32'(rd_addr_q.size()), 2);
        if (rd_addr_q.size() == 2) begin
            chk("s1_raddr0", 32'(rd_addr_q[0]), 32'h100);
            chk("s1_raddr1", 32'(rd_addr_q[1]), 32'h101);
        end
        chk("s1_level", 32'(level), 1);
        chk("s1_src_valid", 32'(src_valid), 1);
        chk("s1_src_data", 32'(src_data), 32'h1111);
        tick();
        src_ready = 1'b1;
        idle(8);
        chk("s1_nout", 32'(out_q.size()), 3);
        if (out_q.size() == 3) begin
            chk("s1_out0", 32'(out_q[0]), 32'h1111);
            chk("s1_out1", 32'(out_q[1]), 32'h2222);
            chk("s1_out2", 32'(out_q[2]), 32'h3333);
        end

        // Scenario 2: fill to full with reads blocked by exhausted credits
        do_reset();
        for (int i = 0; i < 8; i++) push(16'h2000 + 16'(i));
        @(negedge clk);
        chk("s2_level6", 32'(level), 6);
        chk("s2_nrd", 32'(rd_addr_q.size()), 2);
        tick();
        push(16'h2008);
        push(16'h2009);
        @(negedge clk);
        chk("s2_level8", 32'(level), 8);
        tick();
        snk_valid = 1'b1;
        snk_data  = 16'h200A;
        repeat (4) begin
            @(negedge clk);
            chk("s2_full_rdy", 32'(snk_ready), 0);
            chk("s2_full_cs", 32'(m_chipselect), 0);
            chk("s2_full_lvl", 32'(level), 8);
            tick();
        end
        src_ready = 1'b1;
        push(16'h200A);
        idle(30);
        check_stream("s2_out");

        // Scenario 3: stream 20 words with an always-ready consumer
        do_reset();
        src_ready = 1'b1;
        for (int i = 0; i < 20; i++) push(16'h3000 + 16'(i));
        idle(10);
        chk("s3_nwr", 32'(wr_addr_q.size()), 20);
        for (int k = 0; k < 20; k++)
            if (k < wr_addr_q.size()) chk("s3_waddr", 32'(wr_addr_q[k]), 32'h100 + 32'(k % 8));
        check_stream("s3_out");

        // Scenario 4: write/read alternation under contention
        do_reset();
        src_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(16'h4000 + 16'(i));
        idle(6);
        chk("s4_ngnt", 32'(gnt_w_q.size()), 12);
        for (int k = 0; k < 12; k++)
            if (k < gnt_w_q.size()) begin
                chk("s4_kind", 32'(gnt_w_q[k]), 32'(k % 2 == 0));
                chk("s4_cyc", 32'(gnt_c_q[k] - gnt_c_q[0]), 32'(k));
            end
        for (int k = 0; k < 6; k++)
            if (k < rd_addr_q.size()) chk("s4_raddr", 32'(rd_addr_q[k]), 32'h100 + 32'(k));

        // Scenario 5: 200 words with random consumer backpressure
        do_reset();
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) push(16'h5000 + 16'(i * 37));
        idle(60);
        rand_rdy = 1'b0;
        tick();
        check_stream("s5_out");

        // Scenario 6: flush one cycle after a read grant
        do_reset();
        push(16'h6001);
        @(negedge clk);
        chk("s6_rd_cs", 32'(m_chipselect), 1);
        chk("s6_rd_we", 32'(m_write), 0);
        chk("s6_rd_addr", 32'(m_address), 32'h100);
        tick();
        flush     = 1'b1;
        snk_valid = 1'b1;
        snk_data  = 16'h5555;
        @(negedge clk);
        chk("s6_fl_rdy", 32'(snk_ready), 0);
        chk("s6_fl_cs", 32'(m_chipselect), 0);
        chk("s6_late_rdata", 32'(m_readdata), 32'h6001);
        tick();
        flush     = 1'b0;
        snk_valid = 1'b0;
        @(negedge clk);
        chk("s6_post_level", 32'(level), 0);
        chk("s6_post_valid", 32'(src_valid), 0);
        idle(3);
        @(negedge clk);
        chk("s6_still_empty", 32'(src_valid), 0);
        tick();
        out_q.delete();
        wr_addr_q.delete();
        push(16'hABCD);
        chk("s6_nwr", 32'(wr_addr_q.size()), 1);
        if (wr_addr_q.size() == 1) chk("s6_waddr", 32'(wr_addr_q[0]), 32'h100);
        @(negedge clk);
        chk("s6_t1_rd", 32'(m_chipselect && !m_write), 1);
        chk("s6_t1_addr", 32'(m_address), 32'h100);
        chk("s6_t1_valid", 32'(src_valid), 0);
        tick();
        @(negedge clk);
        chk("s6_t2_valid", 32'(src_valid), 0);
        tick();
        @(negedge clk);
        chk("s6_t3_valid", 32'(src_valid), 1);
        chk("s6_t3_data", 32'(src_data), 32'hABCD);
        tick();
        src_ready = 1'b1;
        idle(3);
        chk("s6_nout", 32'(out_q.size()), 1);
        if (out_q.size() == 1) chk("s6_out", 32'(out_q[0]), 32'hABCD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout cycles=%0d limit=50000", cyc);
        $fatal(1, "watchdog");
    end

endmodule
